// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: I-cache request/response, pipeline control and decode-side outputs.
// master = the fetch queue itself, slave = the surrounding pipeline (cache, decode, branch unit).
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  logic [31:0]              FETCH_PC;
  logic                     FETCH_REQ;
  logic                     INS_CACHE_READY;
  logic [31:0]              INS_CACHE_DATA;
  logic                     DATA_CACHE_READY;
  logic                     STALL_ENABLE;
  logic                     FLUSH;
  logic [31:0]              BRANCH_ADDR;
  logic [31:0]              INSTRUCTION;
  logic [31:0]              PC_OUT;
  logic                     INS_VALID;
  logic [$clog2(DEPTH):0]   QUEUE_COUNT;

  modport master (
    output FETCH_PC, FETCH_REQ, INSTRUCTION, PC_OUT, INS_VALID, QUEUE_COUNT,
    input  INS_CACHE_READY, INS_CACHE_DATA, DATA_CACHE_READY, STALL_ENABLE,
           FLUSH, BRANCH_ADDR
  );

  modport slave (
    input  FETCH_PC, FETCH_REQ, INSTRUCTION, PC_OUT, INS_VALID, QUEUE_COUNT,
    output INS_CACHE_READY, INS_CACHE_DATA, DATA_CACHE_READY, STALL_ENABLE,
           FLUSH, BRANCH_ADDR
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC generation plus a DEPTH-entry circular FIFO feeding decode.
// Optional zero-latency empty-queue bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
  input logic           CLK,
  input logic           RSTN,
  fetch_queue_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]    pc_mem_q  [DEPTH];
  logic [31:0]    ins_mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;

  logic empty;
  logic pop;
  logic push;
  logic fetch_req;
  logic bypass;
  logic bypass_pop;
  logic wr_en;

  assign empty     = (count_q == '0);
  assign pop       = bus.STALL_ENABLE & bus.DATA_CACHE_READY & ~empty & ~bus.FLUSH;
  assign fetch_req = (count_q < CW'(DEPTH)) | pop;
  assign push      = fetch_req & bus.INS_CACHE_READY & bus.DATA_CACHE_READY & ~bus.FLUSH;

`ifdef FETCH_QUEUE_BYPASS_EN
  // A word arriving into an empty queue goes straight to decode; if decode
  // takes it this cycle it never occupies a FIFO slot.
  assign bypass     = empty & push;
  assign bypass_pop = bypass & bus.STALL_ENABLE;
`else
  assign bypass     = 1'b0;
  assign bypass_pop = 1'b0;
`endif

  assign wr_en = push & ~bypass_pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    valid_d    = valid_q;
    if (bus.FLUSH) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      valid_d    = '0;
      fetch_pc_d = bus.BRANCH_ADDR;
    end else begin
      // Clear before set: when full with push&pop both pointers coincide.
      if (pop) begin
        valid_d[rd_ptr_q] = 1'b0;
        rd_ptr_d          = rd_ptr_q + PW'(1);
      end
      if (wr_en) begin
        valid_d[wr_ptr_q] = 1'b1;
        wr_ptr_d          = wr_ptr_q + PW'(1);
      end
      if (push) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (wr_en && !pop) begin
        count_d = count_q + CW'(1);
      end else if (!wr_en && pop) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      pc_mem_q[wr_ptr_q]  <= fetch_pc_q;
      ins_mem_q[wr_ptr_q] <= bus.INS_CACHE_DATA;
    end
  end

  always_comb begin
    bus.INSTRUCTION = NOP_INS;
    bus.PC_OUT      = '0;
    bus.INS_VALID   = 1'b0;
    if (!empty) begin
      bus.INSTRUCTION = ins_mem_q[rd_ptr_q];
      bus.PC_OUT      = pc_mem_q[rd_ptr_q];
      bus.INS_VALID   = valid_q[rd_ptr_q];
    end else if (bypass) begin
      bus.INSTRUCTION = bus.INS_CACHE_DATA;
      bus.PC_OUT      = fetch_pc_q;
      bus.INS_VALID   = 1'b1;
    end
  end

  assign bus.FETCH_PC    = fetch_pc_q;
  assign bus.FETCH_REQ   = fetch_req;
  assign bus.QUEUE_COUNT = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic against a queue model.
module tb_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INS  = 32'h0000_0013;

  logic clk;
  logic rstn;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC),
    .NOP_INS (NOP_INS)
  ) dut (
    .CLK (clk),
    .RSTN(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference: ordered list of {pc, ins} still owed to decode, plus the next fetch PC.
  logic [63:0] mq[$];
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input logic icr, input logic dcr, input logic stall,
                        input logic flush, input logic [31:0] baddr);
    bus.INS_CACHE_READY  = icr;
    bus.DATA_CACHE_READY = dcr;
    bus.STALL_ENABLE     = stall;
    bus.FLUSH            = flush;
    bus.BRANCH_ADDR      = baddr;
    bus.INS_CACHE_DATA   = $urandom();
  endtask

  // One clock: compare combinational outputs mid-cycle, then advance the model across the edge.
  task automatic step();
    int unsigned n;
    logic        emp, pop, req, push, byp, byp_pop;
    logic [31:0] e_ins, e_pc;
    logic        e_v;
    @(negedge clk);
    n    = mq.size();
    emp  = (n == 0);
    pop  = bus.STALL_ENABLE && bus.DATA_CACHE_READY && !emp && !bus.FLUSH;
    req  = (n < DEPTH) || pop;
    push = req && bus.INS_CACHE_READY && bus.DATA_CACHE_READY && !bus.FLUSH;
    byp  = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp  = emp && push;
`endif
    byp_pop = byp && bus.STALL_ENABLE;
    if (!emp) begin
      e_pc  = mq[0][63:32];
      e_ins = mq[0][31:0];
      e_v   = 1'b1;
    end else if (byp) begin
      e_pc  = m_pc;
      e_ins = bus.INS_CACHE_DATA;
      e_v   = 1'b1;
    end else begin
      e_pc  = 32'd0;
      e_ins = NOP_INS;
      e_v   = 1'b0;
    end
    check("fetch_pc",  bus.FETCH_PC, m_pc);
    check("fetch_req", 32'(bus.FETCH_REQ), 32'(req));
    check("queue_cnt", 32'(bus.QUEUE_COUNT), 32'(n));
    check("ins_valid", 32'(bus.INS_VALID), 32'(e_v));
    check("pc_out",    bus.PC_OUT, e_pc);
    check("instr",     bus.INSTRUCTION, e_ins);
    @(posedge clk);
    #1;
    if (bus.FLUSH) begin
      mq.delete();
      m_pc = bus.BRANCH_ADDR;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push && !byp_pop) mq.push_back({m_pc, bus.INS_CACHE_DATA});
      if (push) m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic drive(input logic icr, input logic dcr, input logic stall,
                       input logic flush, input logic [31:0] baddr);
    set_in(icr, dcr, stall, flush, baddr);
    step();
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    rstn = 1'b0;
    #1;
    mq.delete();
    m_pc = RESET_PC;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b1;
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_fetch_pc",  bus.FETCH_PC, RESET_PC);
    check("rst_fetch_req", 32'(bus.FETCH_REQ), 32'd1);
    check("rst_valid",     32'(bus.INS_VALID), 32'd0);
    check("rst_instr",     bus.INSTRUCTION, NOP_INS);
    check("rst_pc_out",    bus.PC_OUT, 32'd0);
    check("rst_cnt",       32'(bus.QUEUE_COUNT), 32'd0);
    do_reset();

    // Continuous streaming
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
`ifndef FETCH_QUEUE_BYPASS_EN
    check("stream_cnt", 32'(bus.QUEUE_COUNT), 32'd1);
`endif
    check("stream_pc", bus.FETCH_PC, 32'd32);

    // Decode stalled: fill to full, then drain in order
    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    check("full_cnt", 32'(bus.QUEUE_COUNT), 32'd4);
    check("full_req", 32'(bus.FETCH_REQ), 32'd0);
    check("full_pc",  bus.FETCH_PC, 32'd16);
    check("full_head", bus.PC_OUT, 32'd0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);

    // Flush while holding 0x20..0x2C
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h20);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    check("pre_flush_head", bus.PC_OUT, 32'h20);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
    check("flush_cnt",   32'(bus.QUEUE_COUNT), 32'd0);
    check("flush_valid", 32'(bus.INS_VALID), 32'd0);
    check("flush_instr", bus.INSTRUCTION, 32'h0000_0013);
    check("flush_pc",    bus.FETCH_PC, 32'h100);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    check("flush_deliver", bus.PC_OUT, 32'h100);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);

    // Freeze for 3 cycles with cache ready, then resume
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    // Flush during freeze is still honoured
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h400);
    check("freeze_flush_pc", bus.FETCH_PC, 32'h400);

    // PC wrap at top of address space
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    check("wrap_fetch_pc", bus.FETCH_PC, 32'd0);
    check("wrap_head_pc",  bus.PC_OUT, 32'hFFFF_FFFC);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);

    // Asynchronous reset mid-cycle with three entries queued
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    check("pre_arst_cnt", 32'(bus.QUEUE_COUNT), 32'd3);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_valid", 32'(bus.INS_VALID), 32'd0);
    check("arst_cnt",   32'(bus.QUEUE_COUNT), 32'd0);
    check("arst_pc",    bus.FETCH_PC, RESET_PC);
    do_reset();

`ifdef FETCH_QUEUE_BYPASS_EN
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
    #1;
    check("byp_valid", 32'(bus.INS_VALID), 32'd1);
    step();
    check("byp_cnt", 32'(bus.QUEUE_COUNT), 32'd0);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom() % 4) != 0, ($urandom() % 5) != 0, $urandom() % 2 == 1,
            ($urandom() % 20) == 0, $urandom() & 32'hFFFF_FFFC);
    end
    // Occasional async reset mid-run to exercise recovery
    do_reset();
    for (int i = 0; i < 200; i++) begin
      drive($urandom() % 2 == 1, ($urandom() % 8) != 0, ($urandom() % 3) == 0,
            ($urandom() % 40) == 0, $urandom() & 32'hFFFF_FFFC);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, expected finish before %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch stage sitting directly upstream of the decode unit.
- Generates the fetch PC, captures instruction-cache responses into a small circular FIFO, and presents one instruction per cycle on INSTRUCTION to decode.
- Decouples I-cache timing from decode stalls.
- Squashes all buffered instructions and redirects the PC on FLUSH.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- RESET_PC, 32'h00000000, fetch PC after reset.
- NOP_INS, 32'h00000013, bubble driven to decode when no valid entry (addi x0,x0,0).

Ports:
- CLK  input  1  clock; all state on rising edge.
- RSTN  input  1  asynchronous active-low reset.
- FETCH_PC  output  32  address presented to the I-cache.
- FETCH_REQ  output  1  fetch request; high when the queue can accept a response.
- INS_CACHE_READY  input  1  I-cache returns a valid word for FETCH_PC this cycle.
- INS_CACHE_DATA  input  32  instruction word for FETCH_PC.
- DATA_CACHE_READY  input  1  low = global pipeline freeze.
- STALL_ENABLE  input  1  from decode; high = decode consumes the head this cycle.
- FLUSH  input  1  branch/jump redirect; squash everything.
- BRANCH_ADDR  input  32  redirect target, valid with FLUSH.
- INSTRUCTION  output  32  head instruction to decode, or NOP_INS.
- PC_OUT  output  32  PC of INSTRUCTION; 0 when bubble.
- INS_VALID  output  1  INSTRUCTION is a real fetched word.
- QUEUE_COUNT  output  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async, RSTN=0), registered values:
  - FETCH_PC=RESET_PC
  - both pointers=0
  - QUEUE_COUNT=0
  - all entry valid bits=0
- Reset (async, RSTN=0), resulting outputs: INSTRUCTION=NOP_INS, PC_OUT=0, INS_VALID=0, FETCH_REQ=1.
- Reset mid-operation discards queue contents and the PC immediately.
- Storage: DEPTH entries of {pc[31:0], ins[31:0]}.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Full when count==DEPTH; empty when count==0.
- Freeze: DATA_CACHE_READY=0 holds every register unchanged; outputs stay stable. FLUSH is still honoured during freeze; FLUSH has priority.
- FETCH_REQ = (count<DEPTH) | pop. Asserted combinationally; depends only on current count and pop.
- push = FETCH_REQ & INS_CACHE_READY & DATA_CACHE_READY & !FLUSH.
- pop = STALL_ENABLE & DATA_CACHE_READY & !empty & !FLUSH.
- On push:
  - Entry[wr_ptr] <= {FETCH_PC, INS_CACHE_DATA}.
  - wr_ptr++.
  - FETCH_PC <= FETCH_PC+4, 32-bit wrap (32'hFFFFFFFC+4 = 0).
- On pop: rd_ptr++.
- Count update:
  - push&pop: count unchanged. Legal when full; FETCH_REQ stays high in that case.
  - push only: count+1.
  - pop only: count-1.
- FLUSH (registered effect, single cycle):
  - count=0, rd_ptr=wr_ptr=0.
  - FETCH_PC <= BRANCH_ADDR.
  - The cache response arriving that cycle is dropped.
  - The next cycle fetches BRANCH_ADDR.
- Output, no bypass:
  - INSTRUCTION/PC_OUT/INS_VALID driven combinationally from entry[rd_ptr] when !empty, else NOP_INS/0/0.
  - A pushed word is visible at decode the cycle after capture (1-cycle latency).
- STALL_ENABLE=0 with a valid head holds the same head on outputs indefinitely; the queue keeps filling until full, then FETCH_PC stops advancing.
- Empty and STALL_ENABLE=1: no pop; decode sees NOP_INS.
- Ordering: instructions leave strictly in fetch order with no duplication or loss, except on FLUSH.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - When empty and push occurs in the same cycle, INSTRUCTION/PC_OUT/INS_VALID are driven directly from INS_CACHE_DATA/FETCH_PC/1 (0-cycle latency).
  - If pop also fires that cycle, the word is consumed and is not written into the FIFO (count stays 0).
  - If STALL_ENABLE=0, the word is written normally.
- Undefined: no bypass path; the 1-cycle latency above applies.

Test Plan:
- Reset with RESET_PC=0, then INS_CACHE_READY=1 and STALL_ENABLE=1 continuously:
  - FETCH_PC steps 0,4,8,…
  - From cycle 2, decode sees PC_OUT 0,4,8 with INS_VALID=1.
  - QUEUE_COUNT holds at 1.
- STALL_ENABLE=0 with cache always ready:
  - After 4 pushes, QUEUE_COUNT=4, FETCH_REQ=0, FETCH_PC=16.
  - Head stays PC_OUT=0.
  - Releasing STALL_ENABLE pops 0,4,8,12 in order, and FETCH_REQ rises the same cycle as the first pop.
- Queue holding PCs 0x20..0x2C, FLUSH=1 with BRANCH_ADDR=0x100:
  - Next cycle QUEUE_COUNT=0, INSTRUCTION=32'h00000013, INS_VALID=0, FETCH_PC=0x100.
  - The next delivered PC is 0x100.
- DATA_CACHE_READY=0 for 3 cycles while cache ready:
  - FETCH_PC, QUEUE_COUNT and outputs unchanged.
  - Resumes exactly where it left off.
- FETCH_PC=32'hFFFFFFFC pushed: next FETCH_PC=0; entry PC_OUT=32'hFFFFFFFC.
- RSTN pulsed low mid-cycle with count=3: outputs reset immediately (INS_VALID=0, QUEUE_COUNT=0, FETCH_PC=RESET_PC) without waiting for a clock edge.
- With FETCH_QUEUE_BYPASS_EN defined, empty queue, push+pop in the same cycle: INS_VALID=1 in that cycle and QUEUE_COUNT remains 0.
